// File: rtl/coax_pkg.sv
// Shared definitions for the coax transmitter: frame state encoding and
// the fixed bit counts of each frame section.
package coax_pkg;

  typedef enum logic [2:0] {
    S_IDLE           = 3'd0,
    S_QUIESCE        = 3'd1,
    S_CODE_VIOLATION = 3'd2,
    S_SYNC           = 3'd3,
    S_DATA           = 3'd4,
    S_PARITY         = 3'd5,
    S_END_BIT        = 3'd6,
    S_END_CV         = 3'd7
  } state_e;

  localparam int unsigned QUIESCE_BITS   = 5;
  localparam int unsigned DATA_BITS      = 10;
  // Code violation: this many half-bits high, then this many low.
  localparam int unsigned CV_HIGH_HALVES = 3;
  localparam int unsigned CV_LOW_HALVES  = 3;
  localparam int unsigned CV_BITS        = (CV_HIGH_HALVES + CV_LOW_HALVES) / 2;
  // Width of the per-state bit counter (must hold DATA_BITS-1).
  localparam int unsigned BIT_CNT_W      = 4;

endpackage

// File: rtl/coax_tx_bit_timer.sv
// Bit-period timer for the coax transmitter.
// Ports:
//   clk            - clock
//   i_rst_n        - async active-low reset
//   i_clear        - restarts the count at zero on the next edge
//   o_first_half_c - current clock lies in the first half of the bit
//   o_mid_bit_c    - current clock is the last of the first half
//   o_end_bit_c    - current clock is the last of the bit
module coax_tx_bit_timer #(
  parameter int unsigned CLOCKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_clear,
  output logic o_first_half_c,
  output logic o_mid_bit_c,
  output logic o_end_bit_c
);

  localparam int unsigned HALF  = CLOCKS_PER_BIT / 2;
  localparam int unsigned CNT_W = $clog2(CLOCKS_PER_BIT);

  logic [CNT_W-1:0] r_cnt;

  // Free-running modulo-CLOCKS_PER_BIT counter with synchronous clear.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear || o_end_bit_c) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_first_half_c = (r_cnt < CNT_W'(HALF));
  assign o_mid_bit_c    = (r_cnt == CNT_W'(HALF - 1));
  assign o_end_bit_c    = (r_cnt == CNT_W'(CLOCKS_PER_BIT - 1));

endmodule

// File: rtl/coax_tx.sv
// Coax transmitter: frames 10-bit words as quiesce, code violation,
// then sync/data/parity per word, then end bit and end code violation.
// Each bit b is sent as !b for the first half-bit and b for the second.
// Ports:
//   clk    - clock
//   reset  - async active-low reset
//   data   - word to send, MSB first
//   load   - word strobe, taken when ready is high
//   ready  - holding register empty
//   tx     - registered line level
//   active - high while a frame is on the line
module coax_tx
  import coax_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] data,
  input  logic       load,
  output logic       ready,
  output logic       tx,
  output logic       active
);

  state_e               r_state;
  logic [BIT_CNT_W-1:0] r_bits;
  logic [9:0]           r_hold;
  logic                 r_full;
  logic [9:0]           r_shift;
  logic                 r_par;
  logic                 r_tx;
  logic                 r_active;
  logic                 r_ready;

  state_e               w_state_n;
  logic [BIT_CNT_W-1:0] w_bits_n;
  logic [9:0]           w_hold_n;
  logic                 w_full_n;
  logic [9:0]           w_shift_n;
  logic                 w_par_n;
  logic                 w_clear;
  logic                 w_to_sync;
  logic                 w_accept;
  logic [9:0]           w_sync_word;
  logic                 w_first_half;
  logic                 w_mid;
  logic                 w_end;
  logic                 w_fh_n;
  logic [BIT_CNT_W:0]   w_half_idx;
  logic                 w_tx_n;
  logic                 w_active_n;
  logic                 w_ready_n;

  coax_tx_bit_timer #(
    .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
  ) u_bit_timer (
    .clk            (clk),
    .i_rst_n        (reset),
    .i_clear        (w_clear),
    .o_first_half_c (w_first_half),
    .o_mid_bit_c    (w_mid),
    .o_end_bit_c    (w_end)
  );

  assign w_accept    = load & r_ready;
  // A word arriving on the very edge parity ends goes straight to the shifter.
  assign w_sync_word = r_full ? r_hold : data;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_bits   <= '0;
      r_hold   <= '0;
      r_full   <= 1'b0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_tx     <= 1'b0;
      r_active <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      r_state  <= w_state_n;
      r_bits   <= w_bits_n;
      r_hold   <= w_hold_n;
      r_full   <= w_full_n;
      r_shift  <= w_shift_n;
      r_par    <= w_par_n;
      r_tx     <= w_tx_n;
      r_active <= w_active_n;
      r_ready  <= w_ready_n;
    end
  end

  // Next-state and datapath sequencing; transitions happen at bit ends.
  always_comb begin
    w_state_n = r_state;
    w_bits_n  = r_bits;
    w_hold_n  = r_hold;
    w_full_n  = r_full;
    w_shift_n = r_shift;
    w_par_n   = r_par;
    w_clear   = 1'b0;
    w_to_sync = 1'b0;

    if (w_accept) begin
      w_hold_n = data;
      w_full_n = 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        w_clear = 1'b1;
        if (r_full || w_accept) begin
          w_state_n = S_QUIESCE;
          w_bits_n  = '0;
        end
      end
      S_QUIESCE: begin
        if (w_end) begin
          if (r_bits == BIT_CNT_W'(QUIESCE_BITS - 1)) begin
            w_state_n = S_CODE_VIOLATION;
            w_bits_n  = '0;
          end else begin
            w_bits_n = r_bits + BIT_CNT_W'(1);
          end
        end
      end
      S_CODE_VIOLATION: begin
        if (w_end) begin
          if (r_bits == BIT_CNT_W'(CV_BITS - 1)) begin
            w_to_sync = 1'b1;
          end else begin
            w_bits_n = r_bits + BIT_CNT_W'(1);
          end
        end
      end
      S_SYNC: begin
        if (w_end) begin
          w_state_n = S_DATA;
          w_bits_n  = '0;
        end
      end
      S_DATA: begin
        if (w_end) begin
          w_shift_n = {r_shift[8:0], 1'b0};
          if (r_bits == BIT_CNT_W'(DATA_BITS - 1)) begin
            w_state_n = S_PARITY;
            w_bits_n  = '0;
          end else begin
            w_bits_n = r_bits + BIT_CNT_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (w_end) begin
          if (r_full || w_accept) begin
            w_to_sync = 1'b1;
          end else begin
            w_state_n = S_END_BIT;
          end
        end
      end
      S_END_BIT: begin
        if (w_end) begin
          w_state_n = S_END_CV;
        end
      end
      S_END_CV: begin
        if (w_end) begin
          w_state_n = S_IDLE;
        end
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase

    // Entering SYNC empties the holding register into the shifter.
    if (w_to_sync) begin
      w_state_n = S_SYNC;
      w_bits_n  = '0;
      w_shift_n = w_sync_word;
      w_par_n   = ^w_sync_word;
      w_full_n  = 1'b0;
    end
  end

  // Half-bit position of the next clock, derived from the current strobes.
  assign w_fh_n     = w_clear | (w_first_half & ~w_mid) | w_end;
  assign w_half_idx = {w_bits_n, ~w_fh_n};

  // Output levels for the next clock, so tx/active register in step.
  always_comb begin
    w_tx_n     = 1'b0;
    w_active_n = (w_state_n != S_IDLE);
    w_ready_n  = ~w_full_n;
    case (w_state_n)
      S_QUIESCE:        w_tx_n = 1'b1 ^ w_fh_n;
      S_CODE_VIOLATION: w_tx_n = (w_half_idx < (BIT_CNT_W + 1)'(CV_HIGH_HALVES));
      S_SYNC:           w_tx_n = 1'b1 ^ w_fh_n;
      S_DATA:           w_tx_n = w_shift_n[9] ^ w_fh_n;
      S_PARITY:         w_tx_n = w_par_n ^ w_fh_n;
      S_END_BIT:        w_tx_n = w_fh_n;
      S_END_CV:         w_tx_n = 1'b1;
      default:          w_tx_n = 1'b0;
    endcase
  end

  assign tx     = r_tx;
  assign active = r_active;
  assign ready  = r_ready;

endmodule
